// File: rtl/ce_sched.sv
// ce_sched: clock-enable scheduler with speed selection, contention stall and lock-based reset sequencing
module ce_sched (
  input  logic       clock,
  input  logic       reset,
  input  logic       locked,
  input  logic [1:0] turbo,
  input  logic       contend,
  output logic       rst_out,
  output logic       ce7p,
  output logic       ce7n,
  output logic       cep,
  output logic       cen,
  output logic [1:0] speed
);
  typedef enum logic [1:0] {HOLD, RUN, STALL} state_t;
  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic [9:0] lock_cnt, lock_nx;
  logic [1:0] lsync, speed_nx;
  logic rst_nx, slot_p, slot_n, cep_nx, cen_nx;
  always_comb begin
    cnt_nx = cnt + 4'd1;
    speed_nx = cnt == 4'd15 ? (turbo[1] ? 2'b10 : turbo) : speed;
    lock_nx = !lsync[1] ? 10'd0 : &lock_cnt ? lock_cnt : lock_cnt + 10'd1;
    rst_nx = ~&lock_nx;
    slot_p = speed_nx == 2'b00 ? cnt_nx == 4'd0 : speed_nx == 2'b01 ? cnt_nx[2:0] == 3'd0 : cnt_nx[1:0] == 2'd0;
    slot_n = speed_nx == 2'b00 ? cnt_nx == 4'd8 : speed_nx == 2'b01 ? cnt_nx[2:0] == 3'd4 : cnt_nx[1:0] == 2'd2;
    state_nx = state;
    cep_nx = 1'b0;
    cen_nx = 1'b0;
    if (rst_nx) state_nx = HOLD;
    else if (state == RUN) begin
      state_nx = slot_p && contend ? STALL : RUN;
      cep_nx = slot_p && !contend;
      cen_nx = slot_n;
    end else if (slot_p && (state == HOLD || !contend)) begin
      state_nx = RUN;
      cep_nx = 1'b1;
    end
  end
  always_ff @(posedge clock)
    if (reset) state <= HOLD;
    else state <= state_nx;
  always_ff @(posedge clock)
    if (reset) begin
      cnt <= 4'd0;
      speed <= 2'b00;
      lock_cnt <= 10'd0;
      lsync <= 2'b00;
      rst_out <= 1'b1;
      ce7p <= 1'b0;
      ce7n <= 1'b0;
      cep <= 1'b0;
      cen <= 1'b0;
    end else begin
      cnt <= cnt_nx;
      speed <= speed_nx;
      lock_cnt <= lock_nx;
      lsync <= {lsync[0], locked};
      rst_out <= rst_nx;
      ce7p <= cnt_nx[2:0] == 3'd0;
      ce7n <= cnt_nx[2:0] == 3'd4;
      cep <= cep_nx;
      cen <= cen_nx;
    end
endmodule
